// File: rtl/iic_slave_module_if.sv
// Register-port bundle between the I2C target and a user register file.
// Reg_Addr, WrData and Busy are levels; Wr_Sig and Rd_Sig are one-cycle strobes
// with no back-pressure.
// Wr_Sig means "write WrData to Reg_Addr" in that cycle. Rd_Sig requests the byte
// at Reg_Addr; RdData must hold it from the next cycle on, and it is captured two
// cycles after the strobe.
interface iic_slave_module_if;
  logic [7:0] Reg_Addr;
  logic       Wr_Sig;
  logic [7:0] WrData;
  logic       Rd_Sig;
  logic [7:0] RdData;
  logic       Busy;
  logic [3:0] dbg_state;

  modport slave (
    output Reg_Addr,
    output Wr_Sig,
    output WrData,
    output Rd_Sig,
    output Busy,
    output dbg_state,
    input  RdData
  );

  modport master (
    input  Reg_Addr,
    input  Wr_Sig,
    input  WrData,
    input  Rd_Sig,
    input  Busy,
    input  dbg_state,
    output RdData
  );
endinterface

// File: rtl/iic_slave_module.sv
// EEPROM-style I2C target: oversamples SCL/SDA on CLK and turns byte writes and
// random/sequential reads into register-port strobes.
module iic_slave_module #(
  parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic SCL,
  inout  wire  SDA,
  iic_slave_module_if.slave regs
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_REG      = 4'd3;
  localparam logic [3:0] ST_REG_ACK  = 4'd4;
  localparam logic [3:0] ST_WR_DATA  = 4'd5;
  localparam logic [3:0] ST_WR_ACK   = 4'd6;
  localparam logic [3:0] ST_RD_DATA  = 4'd7;
  localparam logic [3:0] ST_RD_ACK   = 4'd8;

  // ACK-slot progress: 0 waits for the fall that opens the slot, 1 waits for
  // the 9th rise, 2 waits for the fall that closes the slot.
  localparam logic [1:0] ACK_OPEN  = 2'd0;
  localparam logic [1:0] ACK_RISE  = 2'd1;
  localparam logic [1:0] ACK_CLOSE = 2'd2;

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;
  logic       sda_hist;
  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;

  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic [1:0] ack_phase;
  logic [7:0] shift;
  logic [7:0] shift_in;
  logic [7:0] rd_buf;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       rw;
  logic       sda_oe;
  logic       wr_sig;
  logic       rd_sig;
  logic       rd_pend;
  logic       rd_cap;

  // Lines reset to the idle-high level so releasing reset never fakes an edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl_s      = scl_sync[1];
  assign sda_s      = sda_sync[1];
  assign scl_rise   = scl_s & ~scl_hist;
  assign scl_fall   = ~scl_s & scl_hist;
  assign start_cond = scl_s & scl_hist & ~sda_s & sda_hist;
  assign stop_cond  = scl_s & scl_hist & sda_s & ~sda_hist;
  assign shift_in   = {shift[6:0], sda_s};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      ack_phase <= ACK_OPEN;
      shift     <= 8'h00;
      rd_buf    <= 8'h00;
      reg_addr  <= 8'h00;
      wr_data   <= 8'h00;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      wr_sig    <= 1'b0;
      rd_sig    <= 1'b0;
      rd_pend   <= 1'b0;
      rd_cap    <= 1'b0;
    end else begin
      wr_sig  <= 1'b0;
      rd_sig  <= rd_pend;
      rd_pend <= 1'b0;
      rd_cap  <= rd_sig;
      if (rd_cap) rd_buf <= RdData_in();

      if (start_cond) begin
        state     <= ST_ADDR;
        bit_cnt   <= 3'd0;
        ack_phase <= ACK_OPEN;
        sda_oe    <= 1'b0;
      end else if (stop_cond) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;

          ST_ADDR: begin
            if (scl_rise) begin
              shift <= shift_in;
              if (bit_cnt == 3'd7) begin
                bit_cnt   <= 3'd0;
                ack_phase <= ACK_OPEN;
                if (shift[6:0] == DEV_ADDR) begin
                  rw     <= sda_s;
                  rd_sig <= sda_s;
                  state  <= ST_ADDR_ACK;
                end else begin
                  state <= ST_IDLE;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          ST_REG, ST_WR_DATA: begin
            if (scl_rise) begin
              shift <= shift_in;
              if (bit_cnt == 3'd7) begin
                bit_cnt   <= 3'd0;
                ack_phase <= ACK_OPEN;
                if (state == ST_REG) begin
                  reg_addr <= shift_in;
                  state    <= ST_REG_ACK;
                end else begin
                  wr_data <= shift_in;
                  wr_sig  <= 1'b1;
                  state   <= ST_WR_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: begin
            if (scl_fall && ack_phase == ACK_OPEN) begin
              sda_oe    <= 1'b1;
              ack_phase <= ACK_RISE;
            end else if (scl_rise && ack_phase == ACK_RISE) begin
              ack_phase <= ACK_CLOSE;
            end else if (scl_fall && ack_phase == ACK_CLOSE) begin
              ack_phase <= ACK_OPEN;
              bit_cnt   <= 3'd0;
              if (state == ST_ADDR_ACK && rw) begin
                // First read byte goes out on the very fall that ends the ACK.
                shift  <= rd_buf;
                sda_oe <= ~rd_buf[7];
                state  <= ST_RD_DATA;
              end else if (state == ST_ADDR_ACK) begin
                sda_oe <= 1'b0;
                state  <= ST_REG;
              end else begin
                sda_oe <= 1'b0;
                if (state == ST_WR_ACK) reg_addr <= reg_addr + 8'd1;
                state <= ST_WR_DATA;
              end
            end
          end

          ST_RD_DATA: begin
            if (scl_rise) begin
              if (bit_cnt == 3'd7) begin
                bit_cnt   <= 3'd0;
                ack_phase <= ACK_OPEN;
                state     <= ST_RD_ACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else if (scl_fall) begin
              shift  <= {shift[6:0], 1'b0};
              sda_oe <= ~shift[6];
            end
          end

          ST_RD_ACK: begin
            if (scl_fall && ack_phase == ACK_OPEN) begin
              sda_oe    <= 1'b0;
              ack_phase <= ACK_RISE;
            end else if (scl_rise && ack_phase == ACK_RISE) begin
              if (sda_s) begin
                state <= ST_IDLE;
              end else begin
                reg_addr  <= reg_addr + 8'd1;
                rd_pend   <= 1'b1;
                ack_phase <= ACK_CLOSE;
              end
            end else if (scl_fall && ack_phase == ACK_CLOSE) begin
              shift     <= rd_buf;
              sda_oe    <= ~rd_buf[7];
              bit_cnt   <= 3'd0;
              ack_phase <= ACK_OPEN;
              state     <= ST_RD_DATA;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  function automatic logic [7:0] RdData_in();
    return regs.RdData;
  endfunction

  assign SDA            = sda_oe ? 1'b0 : 1'bz;
  assign regs.Reg_Addr  = reg_addr;
  assign regs.WrData    = wr_data;
  assign regs.Wr_Sig    = wr_sig;
  assign regs.Rd_Sig    = rd_sig;
  assign regs.Busy      = (state != ST_IDLE);
  assign regs.dbg_state = state;

endmodule

// File: tb/tb_iic_slave_module.sv
// Directed bench for iic_slave_module: a bit-banged I2C master, a registered
// user memory answering Rd_Sig, and monitors that log every strobe.
module tb_iic_slave_module;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_drv = 1'b0;
  wire  sda;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [256];
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] rd_addr_q[$];
  int         slave_low_cnt = 0;

  assign sda = sda_drv ? 1'b0 : 1'bz;
  pullup pu_sda (sda);

  iic_slave_module_if bus ();

  iic_slave_module #(.DEV_ADDR(7'b1010000)) dut (
    .CLK (clk),
    .RSTn(rst_n),
    .SCL (scl),
    .SDA (sda),
    .regs(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // User register file: answers one cycle after Rd_Sig.
  always @(posedge clk) begin
    if (bus.Rd_Sig) bus.RdData <= mem[bus.Reg_Addr];
  end

  always @(negedge clk) begin
    if (bus.Wr_Sig) begin
      wr_addr_q.push_back(bus.Reg_Addr);
      wr_data_q.push_back(bus.WrData);
    end
    if (bus.Rd_Sig) rd_addr_q.push_back(bus.Reg_Addr);
    if (!sda_drv && sda === 1'b0) slave_low_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    slave_low_cnt = 0;
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; wait_clks(HALF);
    scl = 1'b0;     wait_clks(HALF);
  endtask

  task automatic bus_rstart();
    sda_drv = 1'b0; wait_clks(HALF);
    scl = 1'b1;     wait_clks(HALF);
    sda_drv = 1'b1; wait_clks(HALF);
    scl = 1'b0;     wait_clks(HALF);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b1; wait_clks(HALF);
    scl = 1'b1;     wait_clks(HALF);
    sda_drv = 1'b0; wait_clks(HALF);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_drv = ~b; wait_clks(HALF);
    scl = 1'b1;   wait_clks(HALF);
    s = sda;
    scl = 1'b0;   wait_clks(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic s9);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~mack, s9);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda_drv = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    vectors++; if (bus.Reg_Addr !== 8'h00) begin miscompares++; $display("FAIL rst_reg_addr: got %h want 00", bus.Reg_Addr); end
    vectors++; if (bus.WrData !== 8'h00) begin miscompares++; $display("FAIL rst_wrdata: got %h want 00", bus.WrData); end
    vectors++; if (bus.Wr_Sig !== 1'b0) begin miscompares++; $display("FAIL rst_wr_sig: got %b want 0", bus.Wr_Sig); end
    vectors++; if (bus.Rd_Sig !== 1'b0) begin miscompares++; $display("FAIL rst_rd_sig: got %b want 0", bus.Rd_Sig); end
    vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.Busy); end
    vectors++; if (bus.dbg_state !== 4'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", bus.dbg_state); end
    vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL rst_sda: got %b want 1 (released)", sda); end
  endtask

  task automatic test_single_write();
    logic a0, a1, a2;
    clear_logs();
    bus_start();
    write_byte(8'hA0, a0);
    vectors++; if (bus.Busy !== 1'b1) begin miscompares++; $display("FAIL sw_busy_mid: got %b want 1", bus.Busy); end
    write_byte(8'hAA, a1);
    write_byte(8'h55, a2);
    wait_clks(4);
    vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL sw_acks: got %b want 000", {a0, a1, a2}); end
    vectors++; if (wr_addr_q.size() !== 1) begin miscompares++; $display("FAIL sw_wr_count: got %0d want 1", wr_addr_q.size()); end
    vectors++; if ((wr_addr_q.size() > 0 ? wr_addr_q[0] : 8'h00) !== 8'hAA) begin miscompares++; $display("FAIL sw_wr_addr: got %h want AA", wr_addr_q.size() > 0 ? wr_addr_q[0] : 8'h00); end
    vectors++; if ((wr_data_q.size() > 0 ? wr_data_q[0] : 8'h00) !== 8'h55) begin miscompares++; $display("FAIL sw_wr_data: got %h want 55", wr_data_q.size() > 0 ? wr_data_q[0] : 8'h00); end
    vectors++; if (bus.Reg_Addr !== 8'hAB) begin miscompares++; $display("FAIL sw_reg_addr: got %h want AB", bus.Reg_Addr); end
    bus_stop();
    vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL sw_busy_stop: got %b want 0", bus.Busy); end
  endtask

  task automatic test_random_read();
    logic a0, a1, a2, s9;
    logic [7:0] d;
    clear_logs();
    mem[8'h10] = 8'h3C;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h10, a1);
    bus_rstart();
    write_byte(8'hA1, a2);
    read_byte(1'b0, d, s9);
    vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL rr_acks: got %b want 000", {a0, a1, a2}); end
    vectors++; if (d !== 8'h3C) begin miscompares++; $display("FAIL rr_data: got %h want 3C", d); end
    vectors++; if (s9 !== 1'b1) begin miscompares++; $display("FAIL rr_sda_9th: got %b want 1 (released)", s9); end
    vectors++; if ((rd_addr_q.size() > 0 ? rd_addr_q[0] : 8'h00) !== 8'h10) begin miscompares++; $display("FAIL rr_rd_addr: got %h want 10", rd_addr_q.size() > 0 ? rd_addr_q[0] : 8'h00); end
    bus_stop();
    vectors++; if (rd_addr_q.size() !== 1) begin miscompares++; $display("FAIL rr_rd_count: got %0d want 1", rd_addr_q.size()); end
    vectors++; if (wr_addr_q.size() !== 0) begin miscompares++; $display("FAIL rr_wr_count: got %0d want 0", wr_addr_q.size()); end
    vectors++; if (bus.Reg_Addr !== 8'h10) begin miscompares++; $display("FAIL rr_reg_addr: got %h want 10", bus.Reg_Addr); end
    vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL rr_busy_stop: got %b want 0", bus.Busy); end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    clear_logs();
    bus_start();
    write_byte(8'hA2, a0);
    write_byte(8'h10, a1);
    bus_stop();
    vectors++; if ({a0, a1} !== 2'b11) begin miscompares++; $display("FAIL mm_acks: got %b want 11", {a0, a1}); end
    vectors++; if (slave_low_cnt !== 0) begin miscompares++; $display("FAIL mm_sda_driven: got %0d low cycles want 0", slave_low_cnt); end
    vectors++; if (wr_addr_q.size() + rd_addr_q.size() !== 0) begin miscompares++; $display("FAIL mm_strobes: got %0d want 0", wr_addr_q.size() + rd_addr_q.size()); end
    vectors++; if (bus.Reg_Addr !== 8'h10) begin miscompares++; $display("FAIL mm_reg_addr: got %h want 10", bus.Reg_Addr); end
  endtask

  task automatic test_burst_wrap();
    logic a0, a1, a2, a3;
    clear_logs();
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'hFF, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    bus_stop();
    vectors++; if ({a0, a1, a2, a3} !== 4'b0000) begin miscompares++; $display("FAIL bw_acks: got %b want 0000", {a0, a1, a2, a3}); end
    vectors++; if (wr_addr_q.size() !== 2) begin miscompares++; $display("FAIL bw_wr_count: got %0d want 2", wr_addr_q.size()); end
    vectors++; if ((wr_addr_q.size() > 1 ? {wr_addr_q[0], wr_data_q[0]} : 16'h0) !== 16'hFF11) begin miscompares++; $display("FAIL bw_first: got %h want FF11", wr_addr_q.size() > 1 ? {wr_addr_q[0], wr_data_q[0]} : 16'h0); end
    vectors++; if ((wr_addr_q.size() > 1 ? {wr_addr_q[1], wr_data_q[1]} : 16'h0) !== 16'h0022) begin miscompares++; $display("FAIL bw_second: got %h want 0022", wr_addr_q.size() > 1 ? {wr_addr_q[1], wr_data_q[1]} : 16'h0); end
    vectors++; if (bus.Reg_Addr !== 8'h01) begin miscompares++; $display("FAIL bw_reg_addr: got %h want 01", bus.Reg_Addr); end
  endtask

  task automatic test_seq_read();
    logic a0, a1, a2, s_ack, s9;
    logic [7:0] d0, d1;
    clear_logs();
    mem[8'h20] = 8'hC3;
    mem[8'h21] = 8'h5A;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h20, a1);
    bus_rstart();
    write_byte(8'hA1, a2);
    read_byte(1'b1, d0, s_ack);
    read_byte(1'b0, d1, s9);
    bus_stop();
    vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL sr_acks: got %b want 000", {a0, a1, a2}); end
    vectors++; if ({d0, d1} !== 16'hC35A) begin miscompares++; $display("FAIL sr_data: got %h want C35A", {d0, d1}); end
    vectors++; if (rd_addr_q.size() !== 2) begin miscompares++; $display("FAIL sr_rd_count: got %0d want 2", rd_addr_q.size()); end
    vectors++; if ((rd_addr_q.size() > 1 ? {rd_addr_q[0], rd_addr_q[1]} : 16'h0) !== 16'h2021) begin miscompares++; $display("FAIL sr_rd_addrs: got %h want 2021", rd_addr_q.size() > 1 ? {rd_addr_q[0], rd_addr_q[1]} : 16'h0); end
    vectors++; if (s9 !== 1'b1) begin miscompares++; $display("FAIL sr_sda_9th: got %b want 1", s9); end
    vectors++; if (bus.Reg_Addr !== 8'h21) begin miscompares++; $display("FAIL sr_reg_addr: got %h want 21", bus.Reg_Addr); end
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2, b;
    clear_logs();
    mem[8'h30] = 8'h00;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h30, a1);
    bus_rstart();
    write_byte(8'hA1, a2);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, b);
    wait_clks(4);
    vectors++; if (sda !== 1'b0) begin miscompares++; $display("FAIL mr_sda_low_before: got %b want 0", sda); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL mr_sda_release: got %b want 1", sda); end
    vectors++; if ({bus.Reg_Addr, bus.WrData} !== 16'h0000) begin miscompares++; $display("FAIL mr_regs: got %h want 0000", {bus.Reg_Addr, bus.WrData}); end
    vectors++; if ({bus.Busy, bus.Wr_Sig, bus.Rd_Sig} !== 3'b000) begin miscompares++; $display("FAIL mr_flags: got %b want 000", {bus.Busy, bus.Wr_Sig, bus.Rd_Sig}); end
    scl = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    clear_logs();
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h42, a1);
    write_byte(8'h99, a2);
    bus_stop();
    vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL mr_post_acks: got %b want 000", {a0, a1, a2}); end
    vectors++; if ((wr_addr_q.size() == 1 ? {wr_addr_q[0], wr_data_q[0]} : 16'h0) !== 16'h4299) begin miscompares++; $display("FAIL mr_post_write: got %h want 4299", wr_addr_q.size() == 1 ? {wr_addr_q[0], wr_data_q[0]} : 16'h0); end
    vectors++; if (bus.Reg_Addr !== 8'h43) begin miscompares++; $display("FAIL mr_post_reg_addr: got %h want 43", bus.Reg_Addr); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_write();
    test_random_read();
    test_addr_mismatch();
    test_burst_wrap();
    test_seq_read();
    test_reset_mid_read();
    wait_clks(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
